// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, the NOP encoding and a
// constant-foldable ceil(log2) used to size pointers and counters.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Smallest n with 2**n >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/if_queue_mem.sv
// Storage for the IF/ID fetch queue: a small register array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the owning queue tracks which entries hold live data.
module if_queue_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming entry on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so it is visible the cycle after the write.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch queue between IF and ID. Buffers up to DEPTH {PC, instruction}
// pairs so IF keeps fetching while ID stalls; a taken branch (flush) drops
// every buffered wrong-path entry. When empty, ID sees a NOP with PC 0.
// in_ready and out_valid come from the registered occupancy count only, so
// there is no combinational path from either handshake input to an output.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = mips_pkg::WORD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [WORD_W-1:0]               in_PC,
  input  logic [WORD_W-1:0]               in_instruction,
  output logic                            in_ready,
  input  logic                            flush,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [WORD_W-1:0]               out_PC,
  output logic [WORD_W-1:0]               out_instruction,
  output logic [mips_pkg::clog2(DEPTH):0] count
);

  import mips_pkg::*;

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * WORD_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic             up,
                                                input logic             dn);
    logic [CNT_W-1:0] r;
    r = c;
    if (up && !dn) begin
      r = c + CNT_W'(1);
    end else if (dn && !up) begin
      r = c - CNT_W'(1);
    end
    return r;
  endfunction

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;

  // Handshake decode; flush suppresses both transfers in its cycle.
  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    wdata     = {in_PC, in_instruction};
  end

  if_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy state; reset wins over flush, flush wins over transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= cnt_next(count, push, pop);
    end
  end

  // Present the head entry, or a NOP at PC 0 when nothing is buffered.
  always_comb begin
    out_PC          = '0;
    out_instruction = WORD_W'(MIPS_NOP);
    if (out_valid) begin
      out_PC          = rdata[ENT_W-1:WORD_W];
      out_instruction = rdata[WORD_W-1:0];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios followed by random traffic.
// The driver keeps an occupancy number and pushes each accepted pair into an
// expected-data queue; an independent monitor on the falling edge checks the
// handshake outputs and pops/compares whenever ID consumes an entry.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [WORD_W-1:0] in_PC;
  logic [WORD_W-1:0] in_instruction;
  logic              in_ready;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_PC;
  logic [WORD_W-1:0] out_instruction;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;
  int occ      = 0;
  bit mon_en   = 0;
  logic [63:0] exp_q [$];
  logic [31:0] next_pc;

  if_id_queue #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_PC           (in_PC),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_PC          (out_PC),
    .out_instruction (out_instruction),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; called and returns at posedge+1.
  task automatic step(input bit iv, input bit ordy, input bit fl,
                      input logic [31:0] pc, input logic [31:0] ins);
    bit push;
    bit pop;
    in_valid       = iv;
    in_PC          = pc;
    in_instruction = ins;
    out_ready      = ordy;
    flush          = fl;
    push = iv && (occ != DEPTH) && !fl;
    pop  = (occ != 0) && ordy && !fl;
    if (push) exp_q.push_back({pc, ins});
    @(posedge clk);
    if (fl) occ = 0;
    else    occ = occ + int'(push) - int'(pop);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    occ = 0;
    exp_q.delete();
    #1;
    rst = 1'b0;
  endtask

  // Monitor: handshake outputs against the occupancy model, data against the queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (mon_en && !rst) begin
      chk("mon_count", 64'(count), 64'(occ));
      chk("mon_count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
      chk("mon_in_ready", 64'(in_ready), 64'(occ != DEPTH));
      chk("mon_out_valid", 64'(out_valid), 64'(occ != 0));
      if (!out_valid) begin
        chk("mon_nop_instr", 64'(out_instruction), 64'h0);
        chk("mon_nop_pc", 64'(out_PC), 64'h0);
      end
      if (flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        chk("mon_expected_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("mon_out_pc", 64'(out_PC), 64'(e[63:32]));
          chk("mon_out_instr", 64'(out_instruction), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_PC = '0; in_instruction = '0;

    // 1. Reset and idle, then reset mid-run at count 3.
    do_reset();
    mon_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instruction), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    step(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0);
    chk("idle_count", 64'(count), 64'd0);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 32'(i * 4), 32'hA000_0000 + 32'(i));
    chk("pre_rst_count", 64'(count), 64'd3);
    do_reset();
    chk("midrun_rst_count", 64'(count), 64'd0);
    chk("midrun_rst_valid", 64'(out_valid), 64'd0);

    // 2. Fill with ID stalled.
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 32'(i * 4), 32'h1100_0000 + 32'(i));
      chk("fill_count", 64'(count), 64'(i));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1, 0, 0, 32'd20, 32'h1100_0005);
    chk("full_reject_count", 64'(count), 64'd4);

    // 3. Drain from full.
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_PC), 64'((i + 1) * 4));
      step(0, 1, 0, 32'h0, 32'h0);
      if (i == 0) chk("drain_in_ready", 64'(in_ready), 64'd1);
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_nop", 64'(out_instruction), 64'h0);

    // 4. Streaming with simultaneous push and pop.
    next_pc = 32'h0000_0100;
    step(1, 0, 0, next_pc, $urandom);
    next_pc += 4;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, next_pc, $urandom);
      next_pc += 4;
      chk("stream_count", 64'(count), 64'd1);
    end
    step(0, 1, 0, 32'h0, 32'h0);
    chk("stream_drained_valid", 64'(out_valid), 64'd0);

    // 5. Flush at count 3 with push and pop requested in the same cycle.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, next_pc, $urandom);
      next_pc += 4;
    end
    chk("preflush_count", 64'(count), 64'd3);
    step(1, 1, 1, 32'h0000_BAD0, 32'hDEAD_BEEF);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(1, 0, 0, 32'h0000_1000, 32'h2222_3333);
    chk("postflush_valid", 64'(out_valid), 64'd1);
    chk("postflush_pc", 64'(out_PC), 64'h1000);
    chk("postflush_instr", 64'(out_instruction), 64'h2222_3333);
    step(0, 1, 0, 32'h0, 32'h0);

    // 6. Random traffic.
    for (int i = 0; i < 10000; i++) begin
      bit iv;
      bit ordy;
      bit fl;
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 3);
      step(iv, ordy, fl, next_pc, $urandom);
      next_pc += 4;
    end
    for (int i = 0; i <= DEPTH; i++) step(0, 1, 0, 32'h0, 32'h0);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
